// File: rtl/ex_div_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_pkg
// Shared definitions for the EX-stage iterative divider.
//   DataWidth   : datapath width of the divider (32 only)
//   DataBus     : one datapath word
//   divState_e  : DIV_IDLE / DIV_BUSY / DIV_DONE state encodings
//   ZeroWord    : all-zero word
//   DivByZeroLo : quotient returned for a zero divisor
//   absVal()    : two's-complement magnitude when the operation is signed
// ---------------------------------------------------------------------------
package ex_div_pkg;

   localparam int DataWidth = 32;

   typedef logic [DataWidth-1:0] DataBus;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } divState_e;

   localparam DataBus ZeroWord    = 32'h0000_0000;
   localparam DataBus DivByZeroLo = 32'hFFFF_FFFF;

   // Magnitude of an operand. For a signed operation a negative value is
   // negated. 0x8000_0000 maps onto itself, which is exactly the unsigned
   // magnitude 2^31 the restoring datapath needs.
   function automatic DataBus absVal(input DataBus value, input logic signedOp);
      if (signedOp && value[DataWidth-1]) begin
         return ZeroWord - value;
      end
      return value;
   endfunction

endpackage

// File: rtl/ex_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_i     : partial remainder before the step (always < divisor_i)
//   quo_i     : remaining dividend bits / quotient bits collected so far
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after the step
//   quo_o     : quo_i shifted left with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   remShift;
   logic [WIDTH+1:0] trial;
   logic             fits;

   // Shift {rem,quo} left by one, then try to subtract the divisor. The
   // shifted remainder needs WIDTH+1 bits; one more bit holds the borrow so
   // the sign of the trial difference is unambiguous.
   always_comb begin
      remShift = {rem_i, quo_i[WIDTH-1]};
      trial    = {1'b0, remShift} - {2'b00, divisor_i};
      fits     = ~trial[WIDTH+1];
      rem_o    = fits ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
      quo_o    = {quo_i[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/ex_div.sv
// ---------------------------------------------------------------------------
// ex_div
// Iterative 32-bit MIPS DIV/DIVU unit in the EX stage. One restoring step per
// clock, 32 steps per division; the pipeline is stalled while busy.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   flush      : pipeline flush, aborts any division
//   hold       : downstream stall, keeps a finished result in DONE
//   div_start  : EX holds a DIV/DIVU (level)
//   div_signed : 1 = DIV, 0 = DIVU
//   dividend   : ex_opr1
//   divisor    : ex_opr2
//   div_hi     : remainder (registered)
//   div_lo     : quotient (registered)
//   div_ready  : result valid (registered, DONE only)
//   stallreq   : stall request to the pipeline controller (combinational)
// ---------------------------------------------------------------------------
module ex_div
   import ex_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             hold,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] div_hi,
   output logic [WIDTH-1:0] div_lo,
   output logic             div_ready,
   output logic             stallreq
);

   divState_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   DataBus           rem_q, rem_d;
   DataBus           quo_q, quo_d;
   DataBus           absDivisor_q, absDivisor_d;
   logic             dividendNeg_q, dividendNeg_d;
   logic             divisorNeg_q, divisorNeg_d;
   logic             signed_q, signed_d;
   DataBus           hi_q, hi_d;
   DataBus           lo_q, lo_d;
   logic             ready_q, ready_d;

   DataBus           stepRem;
   DataBus           stepQuo;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_i    (rem_q),
      .quo_i    (quo_q),
      .divisor_i(absDivisor_q),
      .rem_o    (stepRem),
      .quo_o    (stepQuo)
   );

   // Next-state logic. Flush beats everything except reset and leaves the
   // previous result visible on div_hi/div_lo. DONE always drops back to IDLE
   // before a new division can be accepted, so a back-to-back DIV starts one
   // cycle after the previous result was consumed.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      absDivisor_d  = absDivisor_q;
      dividendNeg_d = dividendNeg_q;
      divisorNeg_d  = divisorNeg_q;
      signed_d      = signed_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      ready_d       = ready_q;

      if (flush) begin
         state_d = DIV_IDLE;
         ready_d = 1'b0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (div_start) begin
                  if (divisor == ZeroWord) begin
                     state_d = DIV_DONE;
                     lo_d    = DivByZeroLo;
                     hi_d    = dividend;
                     ready_d = 1'b1;
                  end else begin
                     state_d       = DIV_BUSY;
                     quo_d         = absVal(dividend, div_signed);
                     absDivisor_d  = absVal(divisor, div_signed);
                     rem_d         = ZeroWord;
                     cnt_d         = '0;
                     dividendNeg_d = dividend[WIDTH-1];
                     divisorNeg_d  = divisor[WIDTH-1];
                     signed_d      = div_signed;
                  end
               end
            end

            DIV_BUSY: begin
               rem_d = stepRem;
               quo_d = stepQuo;
               cnt_d = cnt_q + 1'b1;
               // The last step's results go straight through the sign
               // fix-up into the output registers.
               if (cnt_q == {CNT_W{1'b1}}) begin
                  state_d = DIV_DONE;
                  ready_d = 1'b1;
                  lo_d    = (signed_q && (dividendNeg_q ^ divisorNeg_q))
                            ? (ZeroWord - stepQuo) : stepQuo;
                  hi_d    = (signed_q && dividendNeg_q)
                            ? (ZeroWord - stepRem) : stepRem;
               end
            end

            DIV_DONE: begin
               if (!hold) begin
                  state_d = DIV_IDLE;
                  ready_d = 1'b0;
               end
            end

            default: begin
               state_d = DIV_IDLE;
               ready_d = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= DIV_IDLE;
         cnt_q         <= '0;
         rem_q         <= ZeroWord;
         quo_q         <= ZeroWord;
         absDivisor_q  <= ZeroWord;
         dividendNeg_q <= 1'b0;
         divisorNeg_q  <= 1'b0;
         signed_q      <= 1'b0;
         hi_q          <= ZeroWord;
         lo_q          <= ZeroWord;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         absDivisor_q  <= absDivisor_d;
         dividendNeg_q <= dividendNeg_d;
         divisorNeg_q  <= divisorNeg_d;
         signed_q      <= signed_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         ready_q       <= ready_d;
      end
   end

   // Stall while a DIV sits in EX without a result, unless it is being
   // flushed away this cycle.
   always_comb begin
      div_hi    = hi_q;
      div_lo    = lo_q;
      div_ready = ready_q;
      stallreq  = div_start & ~ready_q & ~flush;
   end

endmodule

// File: tb/tb_ex_div.sv
// ---------------------------------------------------------------------------
// tb_ex_div
// Directed plus a few random divisions against ex_div, with expected results
// queued when a division is issued and popped when div_ready rises.
// ---------------------------------------------------------------------------
module tb_ex_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        hold;
   logic        div_start;
   logic        div_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] div_hi;
   logic [31:0] div_lo;
   logic        div_ready;
   logic        stallreq;

   int          vectors = 0;
   int          miscompares = 0;

   logic [31:0] expLoQ[$];
   logic [31:0] expHiQ[$];
   int          expLatQ[$];

   logic [31:0] lastLo;
   logic [31:0] lastHi;
   int          cycles;
   int          stallCycles;

   ex_div #(
      .WIDTH(32),
      .CNT_W(5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .hold      (hold),
      .div_start (div_start),
      .div_signed(div_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .div_hi    (div_hi),
      .div_lo    (div_lo),
      .div_ready (div_ready),
      .stallreq  (stallreq)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison; a miss is reported and counted.
   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Issue a division and queue its expected outcome.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                input logic [31:0] expLo, input logic [31:0] expHi, input int lat);
      expLoQ.push_back(expLo);
      expHiQ.push_back(expHi);
      expLatQ.push_back(lat);
      dividend   = a;
      divisor    = b;
      div_signed = sgn;
      div_start  = 1'b1;
   endtask

   // Count edges and stall cycles until div_ready, bounded.
   task automatic waitResult();
      cycles      = 0;
      stallCycles = 0;
      while (!div_ready && cycles < 100) begin
         #1;
         if (stallreq) stallCycles++;
         @(posedge clk);
         #1;
         cycles++;
      end
      check("ready_rises", {31'd0, div_ready}, 32'd1);
   endtask

   // Pop the scoreboard and compare the finished result.
   task automatic checkOutput(input string tag);
      logic [31:0] eLo;
      logic [31:0] eHi;
      int          eLat;
      if (expLoQ.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL %s_scoreboard: observed empty queue required entry", tag);
         return;
      end
      eLo  = expLoQ.pop_front();
      eHi  = expHiQ.pop_front();
      eLat = expLatQ.pop_front();
      check({tag, "_lo"}, div_lo, eLo);
      check({tag, "_hi"}, div_hi, eHi);
      check({tag, "_latency"}, cycles, eLat);
      check({tag, "_stallcycles"}, stallCycles, eLat);
      #1;
      check({tag, "_stall_done"}, {31'd0, stallreq}, 32'd0);
      lastLo = eLo;
      lastHi = eHi;
   endtask

   // Let the instruction leave EX and confirm DONE -> IDLE.
   task automatic releaseDiv(input string tag);
      div_start = 1'b0;
      tick();
      check({tag, "_ready_drop"}, {31'd0, div_ready}, 32'd0);
   endtask

   task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] expLo, input logic [31:0] expHi);
      applyStimulus(a, b, sgn, expLo, expHi, (b == 32'd0) ? 1 : 33);
      waitResult();
      checkOutput(tag);
      releaseDiv(tag);
   endtask

   initial begin
      logic [31:0]        ra;
      logic [31:0]        rb;
      logic               rs;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0]        mq;
      logic [31:0]        mr;

      rst        = 1'b1;
      flush      = 1'b0;
      hold       = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      dividend   = 32'd0;
      divisor    = 32'd0;
      lastLo     = 32'd0;
      lastHi     = 32'd0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_lo", div_lo, 32'd0);
      check("reset_hi", div_hi, 32'd0);
      check("reset_ready", {31'd0, div_ready}, 32'd0);
      check("reset_stall", {31'd0, stallreq}, 32'd0);

      // Basic unsigned division
      runDiv("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

      // Hold keeps the result in DONE
      applyStimulus(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 33);
      waitResult();
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_ready", {31'd0, div_ready}, 32'd1);
         check("hold_lo", div_lo, 32'd333);
         check("hold_hi", div_hi, 32'd1);
      end
      hold = 1'b0;
      checkOutput("hold_release");
      releaseDiv("hold_release");

      // Signed cases
      runDiv("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      runDiv("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);

      // Divide by zero
      runDiv("div_by_zero", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);

      // Most-negative over minus one, signed and unsigned
      runDiv("ovf_signed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
      runDiv("ovf_unsigned", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);

      // Flush at counter = 10 aborts the division
      dividend   = 32'd100;
      divisor    = 32'd7;
      div_signed = 1'b0;
      div_start  = 1'b1;
      repeat (11) tick();
      flush = 1'b1;
      #1;
      check("flush_stall", {31'd0, stallreq}, 32'd0);
      tick();
      flush     = 1'b0;
      div_start = 1'b0;
      check("flush_ready", {31'd0, div_ready}, 32'd0);
      check("flush_lo_kept", div_lo, lastLo);
      check("flush_hi_kept", div_hi, lastHi);
      tick();
      check("flush_idle_ready", {31'd0, div_ready}, 32'd0);
      runDiv("after_flush_50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0);

      // Reset in the middle of a division
      dividend   = 32'd12345;
      divisor    = 32'd67;
      div_signed = 1'b0;
      div_start  = 1'b1;
      repeat (6) tick();
      rst       = 1'b1;
      div_start = 1'b0;
      tick();
      rst = 1'b0;
      check("midreset_lo", div_lo, 32'd0);
      check("midreset_hi", div_hi, 32'd0);
      check("midreset_ready", {31'd0, div_ready}, 32'd0);
      check("midreset_stall", {31'd0, stallreq}, 32'd0);
      runDiv("after_reset", 32'd12345, 32'd67, 1'b0, 32'd184, 32'd17);

      // A few random operands against a behavioural model
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         rs = 1'($urandom_range(0, 1));
         if (rb == 32'd0) rb = 32'd1;
         if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
         if (rs) begin
            sa = ra;
            sb = rb;
            mq = sa / sb;
            mr = sa % sb;
         end else begin
            mq = ra / rb;
            mr = ra % rb;
         end
         runDiv("random", ra, rb, rs, mq, mr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
